// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and memory-port bundle for dmem_arbiter.
// slave is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              cpu_req, cpu_we, cpu_stall, cpu_rvalid;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata, dma_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
      output dma_gnt, dma_rdata, dma_rvalid,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
      input  dma_gnt, dma_rdata, dma_rvalid,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for a single-port synchronous data memory with DMA bursts.
// Define DMEM_ARB_RR_EN for round-robin on contested idle cycles (default: fixed CPU priority).
module dmem_arbiter #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int BURST_MAX = 4
) (
   input logic             clk,
   input logic             rst_n,
   dmem_arbiter_if.slave   bus
);
   localparam int CW = $clog2(BURST_MAX + 1);
   typedef enum logic {IDLE, DMA_BURST} state_e;
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [1:0]        owner_q, owner_d;
   logic              cpu_gnt, dma_gnt, dma_wins;
   logic [ADDR_W-1:0] addr_w;
   logic [DATA_W-1:0] wdata_w, rdata_w;
`ifdef DMEM_ARB_RR_EN
   logic ptr_q, ptr_d;
   assign dma_wins = ptr_q;
   // pointer names the loser of the last contested idle grant
   assign ptr_d = (state_q == IDLE && bus.cpu_req && bus.dma_req) ? ~dma_gnt : ptr_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
`else
   assign dma_wins = 1'b0;
`endif
   // grants are forced low during reset so nothing reaches memory
   assign dma_gnt = rst_n & bus.dma_req & ((state_q == DMA_BURST) | ~bus.cpu_req | dma_wins);
   assign cpu_gnt = rst_n & bus.cpu_req & ~dma_gnt;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = {dma_gnt & ~bus.dma_we, cpu_gnt & ~bus.cpu_we};
      if (state_q == IDLE) begin
         state_d = (dma_gnt && !bus.dma_last) ? DMA_BURST : IDLE;
         cnt_d   = (dma_gnt && !bus.dma_last) ? CW'(1) : '0;
      end else if (!bus.dma_req || bus.dma_last || cnt_q == CW'(BURST_MAX - 1)) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else
         cnt_d = cnt_q + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   assign addr_w  = dma_gnt ? bus.dma_addr  : cpu_gnt ? bus.cpu_addr  : '0;
   assign wdata_w = dma_gnt ? bus.dma_wdata : cpu_gnt ? bus.cpu_wdata : '0;
   assign rdata_w = bus.mem_rdata;
   assign bus.mem_en     = cpu_gnt | dma_gnt;
   assign bus.mem_we     = dma_gnt ? bus.dma_we : cpu_gnt & bus.cpu_we;
   assign bus.mem_addr   = addr_w;
   assign bus.mem_wdata  = wdata_w;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_stall  = rst_n & bus.cpu_req & ~cpu_gnt;
   assign bus.cpu_rvalid = owner_q[0];
   assign bus.dma_rvalid = owner_q[1];
   assign bus.cpu_rdata  = owner_q[0] ? rdata_w : '0;
   assign bus.dma_rdata  = owner_q[1] ? rdata_w : '0;
endmodule
